sc_entry_ctrl: RTL

- Front-end controller that sequences the safe-lock core (S0..S3/PROG FSM).
- Conditions the raw BTN[3:0] inputs into single-cycle key strobes.
- Owns failed-attempt counting, the timed lockout, entry inactivity timeout and auto-relock after unlock.
- The core then sees one clean key event per press; lockout policy lives here.

---
 rtl/sc_pkg.sv | 23 ++
 rtl/sc_btn_debounce.sv | 64 ++++++
 rtl/sc_entry_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared types and default timing for the safe-lock entry controller.
package sc_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StEntry  = 4'b0010,
    StOpen   = 4'b0100,
    StLocked = 4'b1000
  } ctrl_state_t;

  // Defaults assume a 100 MHz clock.
  localparam int unsigned DefDebounceCyc = 32'd1_000_000;
  localparam int unsigned DefEntryToCyc  = 32'd500_000_000;
  localparam int unsigned DefLockCyc     = 32'd1_000_000_000;
  localparam int unsigned DefUnlockCyc   = 32'd3_000_000_000;
  localparam int unsigned DefMaxFail     = 32'd3;
  localparam int unsigned DefCntW        = 32'd32;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? max : val + 4'd1;
  endfunction

endpackage

// File: rtl/sc_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, 4-bit debouncer and a strobe on each
// transition of the debounced chord from all-released to any-pressed.
module sc_btn_debounce
  import sc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] btn_raw_i,
  output logic       strobe_o,
  output logic [3:0] code_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC);

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      samp_q, samp_d;
  logic [3:0]      db_q, db_d, db_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            strobe_q, strobe_d;
  logic [3:0]      code_q;

  // cnt counts consecutive identical samples, saturating at DEBOUNCE_CYC.
  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    if (sync2_q != samp_q) begin
      samp_d = sync2_q;
      cnt_d  = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    db_d     = (cnt_d == CntMax) ? samp_d : db_q;
    strobe_d = (db_q != 4'b0000) && (db_prev_q == 4'b0000);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      strobe_q  <= 1'b0;
      code_q    <= '0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      strobe_q  <= strobe_d;
      if (strobe_d) code_q <= db_q;
    end
  end

  assign strobe_o = strobe_q;
  assign code_o   = code_q;

endmodule

// File: rtl/sc_entry_ctrl.sv
// Front-end for the safe-lock core: clean key strobes, failure counting,
// timed lockout, entry inactivity abort and auto-relock after unlock.
module sc_entry_ctrl
  import sc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
  parameter int unsigned ENTRY_TO_CYC = DefEntryToCyc,
  parameter int unsigned LOCK_CYC     = DefLockCyc,
  parameter int unsigned UNLOCK_CYC   = DefUnlockCyc,
  parameter int unsigned MAX_FAIL     = DefMaxFail,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] btn_raw_i,
  input  logic       core_fail_i,
  input  logic       core_ok_i,
  input  logic       core_unlocked_i,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic       abort_o,
  output logic       relock_o,
  output logic       lock_led_o,
  output logic [3:0] fail_cnt_o
);

  if (((64'(ENTRY_TO_CYC) | 64'(LOCK_CYC) | 64'(UNLOCK_CYC)) >> CNT_W) != 64'd0)
  begin : g_cyc_range_err
    $error("sc_entry_ctrl: a *_CYC reload does not fit in CNT_W bits");
  end
  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_max_fail_err
    $error("sc_entry_ctrl: MAX_FAIL must be in 1..15");
  end

  localparam logic [CNT_W-1:0] EntryLd  = CNT_W'(ENTRY_TO_CYC);
  localparam logic [CNT_W-1:0] LockLd   = CNT_W'(LOCK_CYC);
  localparam logic [CNT_W-1:0] UnlockLd = CNT_W'(UNLOCK_CYC);
  localparam logic [3:0]       MaxFail  = 4'(MAX_FAIL);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       fail_q, fail_d, fail_inc;
  logic             unl_prev_q, unl_fall, expire, strobe;
  logic [3:0]       code;

  sc_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .btn_raw_i(btn_raw_i),
    .strobe_o (strobe),
    .code_o   (code)
  );

  assign unl_fall = unl_prev_q & ~core_unlocked_i;
  assign fail_inc = sat_inc(fail_q, MaxFail);
  // Expiring on the step to zero makes a reload of N last exactly N cycles.
  assign expire   = (timer_q <= CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    timer_d  = (timer_q != '0) ? timer_q - CNT_W'(1) : timer_q;
    fail_d   = fail_q;
    abort_o  = 1'b0;
    relock_o = 1'b0;
    unique case (state_q)
      StIdle, StEntry: begin
        if (core_ok_i) begin
          fail_d  = '0;
          state_d = StOpen;
          timer_d = UnlockLd;
        end else if (core_fail_i) begin
          fail_d = fail_inc;
          if (fail_inc == MaxFail) begin
            state_d = StLocked;
            timer_d = LockLd;
            abort_o = 1'b1;
          end else begin
            state_d = StIdle;
            timer_d = '0;
          end
        end else if (state_q == StEntry && expire) begin
          abort_o = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end else if (strobe) begin
          state_d = StEntry;
          timer_d = EntryLd;
        end
      end
      StOpen: begin
        if (unl_fall) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (expire) begin
          relock_o = 1'b1;
          state_d  = StIdle;
          timer_d  = '0;
        end else if (strobe) begin
          timer_d = UnlockLd;
        end
      end
      StLocked: begin
        if (expire) begin
          fail_d  = '0;
          state_d = StIdle;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      fail_q     <= '0;
      unl_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      unl_prev_q <= core_unlocked_i;
    end
  end

  // The debouncer keeps tracking while locked, so a held chord is consumed here.
  assign key_valid_o = strobe && (state_q != StLocked);
  assign key_code_o  = code;
  assign lock_led_o  = (state_q == StLocked);
  assign fail_cnt_o  = fail_q;

endmodule
